pe_array: RTL and testbench

- 2-D grid of ARRAY_DIM x ARRAY_DIM independent multiply-accumulate processing elements (PEs).
- Each PE holds a stationary weight register and an accumulator; no data moves between neighbouring PEs.
- Inputs are fully parallel: every PE gets its own data and weight operand each cycle.
- Used as the compute core of the accelerator datapath; the controller drives weight load, compute enable and clear.

---
 rtl/pe_array.sv | 81 ++++++++
 tb/tb_pe_array.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_array.sv
// pe_array: ARRAY_DIM x ARRAY_DIM grid of weight-stationary MAC elements.
// Each PE is independent; all share enable, acc_clear and weight_load.

module pe #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  acc_clear,
  input  logic                  weight_load,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [DATA_WIDTH-1:0] weight_new,
  output logic [ACC_WIDTH-1:0]  acc
);

  logic [DATA_WIDTH-1:0]   weight;
  logic [2*DATA_WIDTH-1:0] prod;

  // Multiply sees the weight from before the edge, so a same-cycle load
  // only takes effect on the following accumulation.
  assign prod = {{DATA_WIDTH{1'b0}}, data}
              * {{DATA_WIDTH{1'b0}}, weight};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      weight <= '0;
    end else if (weight_load) begin
      weight <= weight_new;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (acc_clear) begin
      acc <= '0;
    end else if (enable) begin
      acc <= acc + ACC_WIDTH'(prod);
    end
  end

endmodule

module pe_array #(
  parameter int ARRAY_DIM  = 16,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          enable,
  input  logic                                          acc_clear,
  input  logic                                          weight_load,
  input  logic [ARRAY_DIM*ARRAY_DIM*DATA_WIDTH-1:0]     data_in,
  input  logic [ARRAY_DIM*ARRAY_DIM*DATA_WIDTH-1:0]     weight_in,
  output logic [ARRAY_DIM*ARRAY_DIM*ACC_WIDTH-1:0]      acc_out
);

  for (genvar r = 0; r < ARRAY_DIM; r++) begin : g_row
    for (genvar c = 0; c < ARRAY_DIM; c++) begin : g_col
      localparam int Idx = r * ARRAY_DIM + c;

      pe #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
      ) u_pe (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .acc_clear   (acc_clear),
        .weight_load (weight_load),
        .data        (data_in[Idx*DATA_WIDTH +: DATA_WIDTH]),
        .weight_new  (weight_in[Idx*DATA_WIDTH +: DATA_WIDTH]),
        .acc         (acc_out[Idx*ACC_WIDTH +: ACC_WIDTH])
      );
    end
  end

endmodule

// File: tb/tb_pe_array.sv
// tb_pe_array: directed tests for the pe_array MAC grid.
// A small 2x2 / 20-bit instance exercises accumulator wraparound quickly.

module tb_pe_array;

  localparam int N  = 16;
  localparam int DW = 8;
  localparam int AW = 32;
  localparam int SN = 2;
  localparam int SA = 20;

  logic clk = 1'b0;
  logic rst_n;
  logic enable, acc_clear, weight_load;
  logic [N*N*DW-1:0] data_in, weight_in;
  logic [N*N*AW-1:0] acc_out;

  logic s_enable, s_acc_clear, s_weight_load;
  logic [SN*SN*DW-1:0] s_data_in, s_weight_in;
  logic [SN*SN*SA-1:0] s_acc_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pe_array #(
    .ARRAY_DIM (N), .DATA_WIDTH (DW), .ACC_WIDTH (AW)
  ) dut (
    .clk (clk), .rst_n (rst_n), .enable (enable),
    .acc_clear (acc_clear), .weight_load (weight_load),
    .data_in (data_in), .weight_in (weight_in),
    .acc_out (acc_out)
  );

  pe_array #(
    .ARRAY_DIM (SN), .DATA_WIDTH (DW), .ACC_WIDTH (SA)
  ) dut_small (
    .clk (clk), .rst_n (rst_n), .enable (s_enable),
    .acc_clear (s_acc_clear), .weight_load (s_weight_load),
    .data_in (s_data_in), .weight_in (s_weight_in),
    .acc_out (s_acc_out)
  );

  function automatic logic [AW-1:0] acc_at(int r, int c);
    return acc_out[(r*N+c)*AW +: AW];
  endfunction

  function automatic logic [SA-1:0] sacc_at(int i);
    return s_acc_out[i*SA +: SA];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    enable = 1'b0; acc_clear = 1'b0; weight_load = 1'b0;
    data_in = '0; weight_in = '0;
    s_enable = 1'b0; s_acc_clear = 1'b0; s_weight_load = 1'b0;
    s_data_in = '0; s_weight_in = '0;
    #12;
    n_checks++;
    if (acc_out !== '0) begin
      n_fail++;
      $display("FAIL reset_held: acc_out nonzero, PE(0,0)=%0d required 0",
               acc_at(0, 0));
    end
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (acc_out !== '0 || s_acc_out !== '0) begin
      n_fail++;
      $display("FAIL reset_release: PE(0,0)=%0d required 0", acc_at(0, 0));
    end
  endtask

  task automatic test_load_compute();
    int bad;
    weight_load = 1'b1;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        weight_in[(r*N+c)*DW +: DW] = DW'(r + 1);
    tick();
    weight_load = 1'b0;
    enable = 1'b1;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        data_in[(r*N+c)*DW +: DW] = DW'(c + 1);
    tick();
    enable = 1'b0;
    n_checks++;
    if (acc_at(2, 3) !== 32'd12) begin
      n_fail++;
      $display("FAIL mac1_pe23: got %0d required 12", acc_at(2, 3));
    end
    n_checks++;
    if (acc_at(15, 15) !== 32'd256) begin
      n_fail++;
      $display("FAIL mac1_pe1515: got %0d required 256", acc_at(15, 15));
    end
    bad = 0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        if (acc_at(r, c) !== 32'((r + 1) * (c + 1))) bad++;
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL mac1_all: %0d PEs wrong, required 0 wrong", bad);
    end
  endtask

  task automatic test_second();
    int bad;
    enable = 1'b1;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        data_in[(r*N+c)*DW +: DW] = DW'(r + c);
    tick();
    enable = 1'b0;
    n_checks++;
    if (acc_at(2, 3) !== 32'd27) begin
      n_fail++;
      $display("FAIL mac2_pe23: got %0d required 27", acc_at(2, 3));
    end
    n_checks++;
    if (acc_at(0, 0) !== 32'd1) begin
      n_fail++;
      $display("FAIL mac2_pe00: got %0d required 1", acc_at(0, 0));
    end
    bad = 0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        if (acc_at(r, c) !== 32'((r + 1) * (c + 1) + (r + c) * (r + 1)))
          bad++;
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL mac2_all: %0d PEs wrong, required 0 wrong", bad);
    end
  endtask

  task automatic test_hold();
    data_in = {(N*N){8'd9}};
    tick();
    tick();
    n_checks++;
    if (acc_at(2, 3) !== 32'd27) begin
      n_fail++;
      $display("FAIL hold_pe23: got %0d required 27", acc_at(2, 3));
    end
  endtask

  task automatic test_clear();
    int bad;
    acc_clear = 1'b1;
    tick();
    acc_clear = 1'b0;
    n_checks++;
    if (acc_at(5, 5) !== 32'd0 || acc_out !== '0) begin
      n_fail++;
      $display("FAIL clear: PE(5,5)=%0d required 0", acc_at(5, 5));
    end
    enable = 1'b1;
    data_in = {(N*N){8'd1}};
    tick();
    enable = 1'b0;
    n_checks++;
    if (acc_at(5, 5) !== 32'd6) begin
      n_fail++;
      $display("FAIL clear_keep_w: PE(5,5)=%0d required 6", acc_at(5, 5));
    end
    bad = 0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        if (acc_at(r, c) !== 32'(r + 1)) bad++;
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL clear_keep_all: %0d PEs wrong, required 0 wrong", bad);
    end
  endtask

  task automatic test_clear_priority();
    acc_clear = 1'b1;
    enable = 1'b1;
    data_in = {(N*N){8'd1}};
    tick();
    acc_clear = 1'b0;
    enable = 1'b0;
    n_checks++;
    if (acc_out !== '0) begin
      n_fail++;
      $display("FAIL clear_priority: PE(15,0)=%0d required 0",
               acc_at(15, 0));
    end
  endtask

  task automatic test_max();
    weight_load = 1'b1;
    weight_in = {(N*N){8'd255}};
    tick();
    weight_load = 1'b0;
    enable = 1'b1;
    data_in = {(N*N){8'd255}};
    repeat (3) tick();
    enable = 1'b0;
    n_checks++;
    if (acc_at(0, 0) !== 32'd195075) begin
      n_fail++;
      $display("FAIL max_pe00: got %0d required 195075", acc_at(0, 0));
    end
    n_checks++;
    if (acc_at(15, 15) !== 32'd195075) begin
      n_fail++;
      $display("FAIL max_pe1515: got %0d required 195075", acc_at(15, 15));
    end
  endtask

  task automatic test_wrap();
    s_weight_load = 1'b1;
    s_weight_in = {(SN*SN){8'd255}};
    tick();
    s_weight_load = 1'b0;
    s_enable = 1'b1;
    s_data_in = {(SN*SN){8'd255}};
    repeat (16) tick();
    s_enable = 1'b0;
    n_checks++;
    if (sacc_at(0) !== 20'd1040400) begin
      n_fail++;
      $display("FAIL wrap_preload: got %0d required 1040400", sacc_at(0));
    end
    s_enable = 1'b1;
    tick();
    s_enable = 1'b0;
    n_checks++;
    if (sacc_at(0) !== 20'd56849) begin
      n_fail++;
      $display("FAIL wrap_pe0: got %0d required 56849", sacc_at(0));
    end
    n_checks++;
    if (sacc_at(3) !== 20'd56849) begin
      n_fail++;
      $display("FAIL wrap_pe3: got %0d required 56849", sacc_at(3));
    end
  endtask

  task automatic test_overlap();
    acc_clear = 1'b1;
    weight_load = 1'b1;
    weight_in = {(N*N){8'd3}};
    tick();
    acc_clear = 1'b0;
    weight_in = {(N*N){8'd7}};
    enable = 1'b1;
    data_in = {(N*N){8'd2}};
    tick();
    weight_load = 1'b0;
    n_checks++;
    if (acc_at(4, 9) !== 32'd6) begin
      n_fail++;
      $display("FAIL overlap_old_w: got %0d required 6", acc_at(4, 9));
    end
    tick();
    enable = 1'b0;
    n_checks++;
    if (acc_at(4, 9) !== 32'd20) begin
      n_fail++;
      $display("FAIL overlap_new_w: got %0d required 20", acc_at(4, 9));
    end
  endtask

  task automatic test_reset_mid();
    enable = 1'b1;
    data_in = {(N*N){8'd1}};
    tick();
    n_checks++;
    if (acc_at(3, 3) !== 32'd27) begin
      n_fail++;
      $display("FAIL mid_before: got %0d required 27", acc_at(3, 3));
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (acc_out !== '0) begin
      n_fail++;
      $display("FAIL mid_async: PE(3,3)=%0d required 0", acc_at(3, 3));
    end
    #3 rst_n = 1'b1;
    data_in = {(N*N){8'd5}};
    tick();
    n_checks++;
    if (acc_out !== '0) begin
      n_fail++;
      $display("FAIL mid_w_zero: PE(3,3)=%0d required 0", acc_at(3, 3));
    end
    enable = 1'b0;
    weight_load = 1'b1;
    weight_in = {(N*N){8'd2}};
    tick();
    weight_load = 1'b0;
    enable = 1'b1;
    tick();
    enable = 1'b0;
    n_checks++;
    if (acc_at(7, 1) !== 32'd10) begin
      n_fail++;
      $display("FAIL mid_reload: got %0d required 10", acc_at(7, 1));
    end
  endtask

  initial begin
    test_reset();
    test_load_compute();
    test_second();
    test_hold();
    test_clear();
    test_clear_priority();
    test_max();
    test_wrap();
    test_overlap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
